// File: rtl/cnn_conv_1x1_layer_ctrl_pkg.sv
// cnn_conv_ctrl_pkg: state encoding and layer-size helpers shared by the conv layer controllers
package cnn_conv_ctrl_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD_W, ST_STREAM, ST_DRAIN, ST_DONE} ctrl_state_t;
    function automatic int w_num(input int cin, input int cout);
        return cin * cout;
    endfunction
    function automatic int p_num(input int w, input int h, input int cin);
        return w * h * cin;
    endfunction
    // stride 2 keeps every other row and column, floor-divided
    function automatic int o_num(input int w, input int h, input int cout, input bit s2);
        return s2 ? cout * (w / 2) * (h / 2) : cout * w * h;
    endfunction
    localparam int W_NUM = w_num(64, 128);
    localparam int P_NUM = p_num(306, 306, 64);
    localparam int O_NUM_S1 = o_num(306, 306, 128, 1'b0);
    localparam int O_NUM_S2 = o_num(306, 306, 128, 1'b1);
    localparam int W_CNT_W = $clog2(W_NUM + 1);
    localparam int P_CNT_W = $clog2(P_NUM + 1);
    localparam int O_CNT_W = $clog2(O_NUM_S1 + 1);
endpackage

// File: rtl/cnn_conv_1x1_layer_ctrl_counter.sv
// cnn_ctrl_counter: clearable up-counter with a one-cycle flag on the increment that reaches TERM
module cnn_ctrl_counter #(
    parameter int WIDTH = 8,
    parameter int TERM = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);
    localparam logic [WIDTH-1:0] TERM_M1 = WIDTH'(TERM - 1);
    assign last = inc && cnt == TERM_M1;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cnn_conv_1x1_layer_ctrl.sv
// cnn_conv_1x1_layer_ctrl: one start runs one 1x1 conv layer pass - load weights, stream pixels,
// count datapath output beats, pulse done.
module cnn_conv_1x1_layer_ctrl
    import cnn_conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMAGE_WIDTH = 306,
    parameter int IMAGE_HEIGHT = 306,
    parameter int CHANNEL_NUM_IN = 64,
    parameter int CHANNEL_NUM_OUT = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_cfg,
    input  logic                  w_valid,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    input  logic                  p_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  p_ready,
    output logic                  valid_weight_in,
    output logic [DATA_WIDTH-1:0] weight_in,
    output logic                  valid_in,
    output logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  stride2,
    input  logic                  dp_valid_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int WN = w_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT);
    localparam int PN = p_num(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_IN);
    localparam int ON1 = o_num(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_OUT, 1'b0);
    localparam int ON2 = o_num(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_OUT, 1'b1);
    localparam int WCW = $clog2(WN + 1);
    localparam int PCW = $clog2(PN + 1);
    localparam int OCW = $clog2(ON1 + 1);
    localparam logic [WCW-1:0] W_TERM = WCW'(WN);
    localparam logic [PCW-1:0] P_TERM = PCW'(PN);
    localparam logic [OCW-1:0] O_TERM1 = OCW'(ON1);
    localparam logic [OCW-1:0] O_TERM2 = OCW'(ON2);
    localparam logic [OCW-1:0] O_LAST2 = OCW'(ON2 - 1);

    ctrl_state_t state, state_nx;
    logic [WCW-1:0] w_cnt;
    logic [PCW-1:0] p_cnt;
    logic [OCW-1:0] o_cnt;
    logic w_last, p_last, o1_last, o_last, w_acc, p_acc, o_win, o_full, o_inc, clr;

    assign clr = state == ST_IDLE && start;
    assign w_ready = state == ST_LOAD_W && w_cnt < W_TERM;
    assign p_ready = state == ST_STREAM && p_cnt < P_TERM;
    assign w_acc = w_valid && w_ready;
    assign p_acc = p_valid && p_ready;
    assign busy = state != ST_IDLE;
    assign done = state == ST_DONE;
    assign o_win = state == ST_STREAM || state == ST_DRAIN;
    assign o_full = o_cnt == (stride2 ? O_TERM2 : O_TERM1);
    assign o_inc = dp_valid_out && o_win && !o_full;
    // the counter is sized and terminated for stride 1; stride 2 checks its own lower terminal
    assign o_last = stride2 ? (o_inc && o_cnt == O_LAST2) : o1_last;

    cnn_ctrl_counter #(.WIDTH(WCW), .TERM(WN)) u_w_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(w_acc), .cnt(w_cnt), .last(w_last)
    );
    cnn_ctrl_counter #(.WIDTH(PCW), .TERM(PN)) u_p_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(p_acc), .cnt(p_cnt), .last(p_last)
    );
    cnn_ctrl_counter #(.WIDTH(OCW), .TERM(ON1)) u_o_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(o_inc), .cnt(o_cnt), .last(o1_last)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ST_IDLE;
        else state <= state_nx;

    // DRAIN also exits on the beat that completes the count, so done lands one cycle after it
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? ST_LOAD_W : ST_IDLE;
            ST_LOAD_W: state_nx = w_last ? ST_STREAM : ST_LOAD_W;
            ST_STREAM: state_nx = p_last ? ST_DRAIN : ST_STREAM;
            ST_DRAIN:  state_nx = (o_full || o_last) ? ST_DONE : ST_DRAIN;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            valid_weight_in <= 1'b0;
            weight_in <= '0;
            valid_in <= 1'b0;
            pxl_in <= '0;
            stride2 <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid_weight_in <= w_acc;
            valid_in <= p_acc;
            if (w_acc) weight_in <= w_data;
            if (p_acc) pxl_in <= p_data;
            if (clr) begin
                stride2 <= stride2_cfg;
                overrun <= 1'b0;
            end else if (dp_valid_out && (!o_win || o_full)) overrun <= 1'b1;
        end
endmodule

// File: doc/cnn_conv_1x1_layer_ctrl.md
# cnn_conv_1x1_layer_ctrl

Layer sequencer for the 1x1 convolution pipeline (loop-data, conv, channel adder, align). It loads all `CHANNEL_NUM_IN*CHANNEL_NUM_OUT` weights from a ready/valid weight source, then streams one full image of pixels from a ready/valid pixel source into the datapath. It counts the datapath's output beats and signals completion, so one `start` runs exactly one layer pass. It sits between the layer memories/DMA and the 1x1 conv top.

## Interface
- `DATA_WIDTH`, 16, pixel/weight word width
- `IMAGE_WIDTH`, 306, input columns
- `IMAGE_HEIGHT`, 306, input rows
- `CHANNEL_NUM_IN`, 64, input channels
- `CHANNEL_NUM_OUT`, 128, output channels
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; sampled in IDLE only
- `stride2_cfg`  in  1  stride-2 select; latched on accepted `start`
- `w_valid` / `w_data` / `w_ready`  in/in/out  1/DATA_WIDTH/1  weight source handshake
- `p_valid` / `p_data` / `p_ready`  in/in/out  1/DATA_WIDTH/1  pixel source handshake
- `valid_weight_in` / `weight_in`  out  1/DATA_WIDTH  to datapath weight port
- `valid_in` / `pxl_in`  out  1/DATA_WIDTH  to datapath pixel port
- `stride2`  out  1  latched stride to datapath
- `dp_valid_out`  in  1  datapath output-valid, counted only
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at layer end
- `overrun`  out  1  sticky: `dp_valid_out` seen outside STREAM/DRAIN, or beyond expected count

## Operation
- Derived constants: `W_NUM = CHANNEL_NUM_IN*CHANNEL_NUM_OUT`; `P_NUM = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM_IN`; `O_NUM = CHANNEL_NUM_OUT*IMAGE_WIDTH*IMAGE_HEIGHT` (stride 1) or `CHANNEL_NUM_OUT*(IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2)` (stride 2, floor division).
- Counter widths are `$clog2(N+1)` for the constant N each counter counts to. Counters are unsigned, and each clears on accepted `start`.
- **IDLE**
  - `start` latches `stride2_cfg`, clears counters and `overrun`, then goes to LOAD_W.
- **LOAD_W**
  - `w_ready=1` while `w_cnt<W_NUM`; each `w_valid&&w_ready` increments `w_cnt`.
  - Goes to STREAM on the cycle the `W_NUM`-th weight is accepted.
- **STREAM**
  - `p_ready=1` while `p_cnt<P_NUM`; each `p_valid&&p_ready` increments `p_cnt`.
  - Goes to DRAIN when the `P_NUM`-th pixel is accepted.
- **DRAIN**
  - Waits for `o_cnt==O_NUM`, then goes to DONE.
  - `o_cnt` increments on `dp_valid_out` in STREAM and DRAIN.
- **DONE**
  - `done=1` for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `w_ready` and `p_ready` are never high in the same cycle, and both are 0 outside their own states.
- Once `o_cnt==O_NUM`, a further `dp_valid_out` sets `overrun` and does not increment the counter. `dp_valid_out` in IDLE, LOAD_W or DONE also sets `overrun`.
- Mid-operation reset: all state returns to IDLE and all outputs take their reset values. The datapath is reset by the same `reset`.

## Timing
- Reset values:
  - all outputs 0 and the FSM in IDLE;
  - `weight_in`/`pxl_in` are 0 and `stride2` is 0.
- Weight path is registered: `valid_weight_in`/`weight_in` follow the accepted `w_valid&&w_ready`/`w_data` by 1 cycle.
- Pixel path is registered the same way: `valid_in`/`pxl_in` follow acceptance by 1 cycle.
- `valid_*` are low in cycles without acceptance, so source bubbles pass through as bubbles.
- `start` accepted at cycle t gives `busy=1` and `w_ready=1` at t+1.
- Last weight accepted at t gives `p_ready=1` at t+1. The last weight reaches the datapath at t+1 and the first pixel no earlier than t+2.
- Last output beat at t gives `done=1` at t+1 (in DONE) and `busy=0` at t+2.
- Throughput is one word per cycle in LOAD_W and in STREAM.

## Structure
- Shared include/package `cnn_conv_ctrl_pkg` holds:
  - state encodings `ST_IDLE`, `ST_LOAD_W`, `ST_STREAM`, `ST_DRAIN`, `ST_DONE`;
  - the derived-count and width localparams (`W_NUM`, `P_NUM`, `O_NUM_S1`, `O_NUM_S2`). Other layer controllers reuse these.
- Sub-module `cnn_ctrl_counter` is natural: parameterised width and terminal value, `clr`, `inc`, `cnt`, and a `last` flag (`inc && cnt==TERM-1`). It is instantiated three times (weights, pixels, outputs).

## Test plan
Bench parameters: W=H=4, CIN=2, COUT=2, so W_NUM=4, P_NUM=32, O_NUM=32 (stride 1) or 8 (stride 2).
- **Nominal stride 1.** Sources are always valid and the output model gives 32 `dp_valid_out` beats. Required: 4 weights then 32 pixels appear in order, each 1 cycle after acceptance; `done` pulses once, 1 cycle after the 32nd output; `overrun=0`.
- **Stride 2.** `stride2_cfg=1` at `start`, then 8 output beats. Required: `stride2=1` for the whole pass; `done` after the 8th beat.
- **Backpressure/bubbles.** `w_valid`/`p_valid` are random at 50%. Required: exactly 4 and 32 `valid_*` pulses, data identical and in order, no duplicates.
- **Ignored start.** Pulse `start` in STREAM. Required: no restart; counts unchanged; a single `done`.
- **Overrun.** Inject 33 beats in stride 1. Required: `overrun=1` on the cycle after the 33rd beat, held until the next `start`; `done` still follows the 32nd beat.
- **Reset mid-stream.** Assert `reset` low after 10 pixels. Required: immediate IDLE with `busy=0`, `p_ready=0` and `valid_in=0`; a new `start` runs a full, correct pass.
